// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drain-side controller for the engine's input FIFO. Issues pops, tracks words
// still in the FIFO's read pipeline, and lands returned words in a small skid
// buffer that feeds the approximation core as a valid/ready stream.
module fifo_stream_reader #(
  parameter int RAM_WIDTH    = 32,
  parameter int READ_LATENCY = 1,
  parameter int BUF_DEPTH    = 4,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 fifo_empty_i,
  input  logic                 fifo_wr_en_i,
  input  logic [RAM_WIDTH-1:0] fifo_data_i,
  output logic                 fifo_rd_en_o,
  output logic [RAM_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 idle_o,
  output logic [CNT_WIDTH-1:0] pop_cnt_o
);

  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int SUM_W = OCC_W + 1;

  // Read-pipeline tracker: bit i set means a pop issued i+1 cycles ago is still returning
  logic [READ_LATENCY-1:0] pend_q, pend_d;

  // Skid buffer state
  logic [RAM_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [RAM_WIDTH-1:0] mem_d [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]     occ_q, occ_d;
  logic [CNT_WIDTH-1:0] pop_cnt_q, pop_cnt_d;

  logic [OCC_W-1:0] inflight;
  logic             has_space;
  logic             push;
  logic             pop;

  // Count words still travelling through the FIFO's read latency
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + OCC_W'(pend_q[i]);
    end
  end

  // Pop only when every buffered and in-flight word is guaranteed a slot; the
  // FIFO drops reads during writes, so never ask then. Held off during reset.
  always_comb begin
    has_space    = ({1'b0, occ_q} + {1'b0, inflight}) < SUM_W'(BUF_DEPTH);
    fifo_rd_en_o = rstn_i & ~fifo_empty_i & ~fifo_wr_en_i & has_space;
  end

  assign push = pend_q[READ_LATENCY-1];
  assign pop  = m_valid_o & m_ready_i;

  // Next-state for the latency shift register, buffer, pointers and counter
  always_comb begin
    pend_d    = pend_q;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    pop_cnt_d = pop_cnt_q;

    pend_d[0] = fifo_rd_en_o;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pend_d[i] = pend_q[i-1];
    end

    if (push) begin
      mem_d[wr_ptr_q] = fifo_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      pop_cnt_d = pop_cnt_q + CNT_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // State registers; reset also wipes buffer contents so nothing stale is ever shown
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pend_q    <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      occ_q     <= '0;
      pop_cnt_q <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      pend_q    <= pend_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      occ_q     <= occ_d;
      pop_cnt_q <= pop_cnt_d;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign m_valid_o = (occ_q != '0);
  assign m_data_o  = mem_q[rd_ptr_q];
  assign idle_o    = (occ_q == '0) && (inflight == '0);
  assign pop_cnt_o = pop_cnt_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader
// Drives fifo_stream_reader from a behavioural FIFO with registered read
// latency and checks the delivered stream against a scoreboard of loaded words.
module tb_fifo_stream_reader;

  localparam int RAM_WIDTH    = 32;
  localparam int READ_LATENCY = 1;
  localparam int BUF_DEPTH    = 4;
  localparam int CNT_WIDTH    = 16;

  logic                 clk_i;
  logic                 rstn_i;
  logic                 fifo_empty_i;
  logic                 fifo_wr_en_i;
  logic [RAM_WIDTH-1:0] fifo_data_i;
  logic                 fifo_rd_en_o;
  logic [RAM_WIDTH-1:0] m_data_o;
  logic                 m_valid_o;
  logic                 m_ready_i;
  logic                 idle_o;
  logic [CNT_WIDTH-1:0] pop_cnt_o;

  fifo_stream_reader #(
    .RAM_WIDTH(RAM_WIDTH),
    .READ_LATENCY(READ_LATENCY),
    .BUF_DEPTH(BUF_DEPTH),
    .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .clk_i(clk_i),
    .rstn_i(rstn_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_wr_en_i(fifo_wr_en_i),
    .fifo_data_i(fifo_data_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .m_data_o(m_data_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .idle_o(idle_o),
    .pop_cnt_o(pop_cnt_o)
  );

  int n_checks = 0;
  int n_fails  = 0;

  logic [RAM_WIDTH-1:0] fifo_q[$];
  logic [RAM_WIDTH-1:0] exp_q[$];
  logic [RAM_WIDTH-1:0] rd_pipe [READ_LATENCY];
  logic [RAM_WIDTH-1:0] wr_word;
  logic [RAM_WIDTH-1:0] model_word;
  logic [RAM_WIDTH-1:0] exp_word;

  int cyc = 0, rd_cnt = 0, valid_cnt = 0;
  int issued = 0, handshakes = 0, delivered = 0;
  int rd_run = 0, last_rd_run = 0, valid_run = 0, last_valid_run = 0;
  int last_rd_cyc = 0, valid_rise_cyc = 0;
  logic prev_stall = 1'b0;
  logic [RAM_WIDTH-1:0] prev_data = '0;

  int base_rd, base_valid;

  // Clock generation
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Single comparison point: counts, asserts and reports any mismatch
  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      $error("[TB] %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Put a word into the FIFO and record it as the next expected stream word
  task automatic apply_stimulus(input logic [RAM_WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  // Wait until the FIFO, the reader and the scoreboard are all drained, bounded
  task automatic wait_drained(input int budget);
    int  n;
    logic done;
    n    = 0;
    done = 1'b0;
    while (!done && n < budget) begin
      done = idle_o && fifo_empty_i && (fifo_q.size() == 0) && (exp_q.size() == 0);
      if (!done) begin
        next_cycle();
        n++;
      end
    end
    check_output("drain_within_budget", 64'(done), 64'd1);
  endtask

  // FIFO model: registered read path of READ_LATENCY stages, empty flag updated at the edge
  always @(posedge clk_i) begin
    model_word = $urandom;
    if (fifo_rd_en_o) begin
      check_output("fifo_no_underflow", 64'(fifo_q.size() != 0), 64'd1);
      if (fifo_q.size() != 0) model_word = fifo_q.pop_front();
    end
    if (fifo_wr_en_i) fifo_q.push_back(wr_word);
    rd_pipe[0] <= model_word;
    for (int i = 1; i < READ_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    fifo_empty_i <= (fifo_q.size() == 0);
  end

  assign fifo_data_i = rd_pipe[READ_LATENCY-1];

  // Stream monitor: scoreboard compare, hold-stability, pop cap and counter tracking
  always @(negedge clk_i) begin
    cyc++;
    if (!rstn_i) begin
      issued     = 0;
      handshakes = 0;
      delivered  = 0;
      rd_run     = 0;
      valid_run  = 0;
      prev_stall = 1'b0;
    end else begin
      check_output("pop_cnt_track", 64'(pop_cnt_o), 64'(CNT_WIDTH'(delivered)));
      if (fifo_wr_en_i) check_output("no_rd_in_wr_cycle", 64'(fifo_rd_en_o), 64'd0);
      if (fifo_rd_en_o) begin
        check_output("pop_cap", 64'((issued - handshakes) < BUF_DEPTH), 64'd1);
        issued++;
        rd_cnt++;
        rd_run++;
        last_rd_cyc = cyc;
      end else begin
        if (rd_run != 0) last_rd_run = rd_run;
        rd_run = 0;
      end
      if (prev_stall) begin
        check_output("valid_held", 64'(m_valid_o), 64'd1);
        check_output("data_held", 64'(m_data_o), 64'(prev_data));
      end
      if (m_valid_o) begin
        if (valid_run == 0) valid_rise_cyc = cyc;
        valid_run++;
        valid_cnt++;
      end else begin
        if (valid_run != 0) last_valid_run = valid_run;
        valid_run = 0;
      end
      if (m_valid_o && m_ready_i) begin
        check_output("word_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          exp_word = exp_q.pop_front();
          check_output("stream_data", 64'(m_data_o), 64'(exp_word));
        end
        handshakes++;
        delivered++;
      end
      prev_stall = m_valid_o & ~m_ready_i;
      prev_data  = m_data_o;
    end
  end

  // Directed sequence
  initial begin
    rstn_i       = 1'b0;
    m_ready_i    = 1'b1;
    fifo_wr_en_i = 1'b0;
    wr_word      = '0;
    fifo_empty_i = 1'b1;

    // Reset held with a non-empty FIFO
    apply_stimulus(32'hA5A50001);
    repeat (3) begin
      next_cycle();
      check_output("rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
      check_output("rst_valid", 64'(m_valid_o), 64'd0);
      check_output("rst_data", 64'(m_data_o), 64'd0);
      check_output("rst_pop_cnt", 64'(pop_cnt_o), 64'd0);
      check_output("rst_idle", 64'(idle_o), 64'd1);
    end

    // Single word
    base_rd    = rd_cnt;
    base_valid = valid_cnt;
    rstn_i     = 1'b1;
    wait_drained(30);
    next_cycle();
    check_output("single_pops", 64'(rd_cnt - base_rd), 64'd1);
    check_output("single_valid_cycles", 64'(valid_cnt - base_valid), 64'd1);
    check_output("single_latency", 64'(valid_rise_cyc - last_rd_cyc), 64'(READ_LATENCY + 1));
    check_output("single_pop_cnt", 64'(pop_cnt_o), 64'd1);
    check_output("single_idle", 64'(idle_o), 64'd1);

    // Streaming eight words at full rate
    base_rd    = rd_cnt;
    base_valid = valid_cnt;
    for (int i = 0; i < 8; i++) apply_stimulus(32'(i));
    wait_drained(40);
    next_cycle();
    check_output("stream_pops", 64'(rd_cnt - base_rd), 64'd8);
    check_output("stream_rd_run", 64'(last_rd_run), 64'd8);
    check_output("stream_valid_run", 64'(last_valid_run), 64'd8);
    check_output("stream_valid_cycles", 64'(valid_cnt - base_valid), 64'd8);
    check_output("stream_pop_cnt", 64'(pop_cnt_o), 64'd9);

    // Backpressure: pops capped at buffer depth, head word held
    m_ready_i  = 1'b0;
    base_rd    = rd_cnt;
    base_valid = valid_cnt;
    for (int i = 0; i < 10; i++) apply_stimulus(32'hB000_0000 + 32'(i));
    repeat (10) next_cycle();
    check_output("bp_pops_capped", 64'(rd_cnt - base_rd), 64'(BUF_DEPTH));
    check_output("bp_valid", 64'(m_valid_o), 64'd1);
    check_output("bp_head_data", 64'(m_data_o), 64'hB000_0000);
    check_output("bp_rd_en_low", 64'(fifo_rd_en_o), 64'd0);
    m_ready_i = 1'b1;
    wait_drained(60);
    next_cycle();
    check_output("bp_pops_total", 64'(rd_cnt - base_rd), 64'd10);
    check_output("bp_pop_cnt", 64'(pop_cnt_o), 64'd19);

    // Write contention: no reads while the writer owns the FIFO
    base_rd = rd_cnt;
    apply_stimulus(32'hC000_0001);
    apply_stimulus(32'hC000_0002);
    fifo_wr_en_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wr_word = 32'hD000_0001 + 32'(k);
      exp_q.push_back(wr_word);
      check_output("wr_blocks_rd", 64'(fifo_rd_en_o), 64'd0);
      next_cycle();
    end
    fifo_wr_en_i = 1'b0;
    #1;
    check_output("rd_resumes_after_wr", 64'(fifo_rd_en_o), 64'd1);
    wait_drained(40);
    next_cycle();
    check_output("wr_pops_total", 64'(rd_cnt - base_rd), 64'd5);
    check_output("wr_pop_cnt", 64'(pop_cnt_o), 64'd24);

    // Reset mid-stream with words buffered and in flight
    m_ready_i = 1'b0;
    for (int i = 0; i < 10; i++) apply_stimulus(32'hE000_0000 + 32'(i));
    repeat (4) next_cycle();
    check_output("mid_busy", 64'(idle_o), 64'd0);
    rstn_i = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    #1;
    check_output("mid_rst_valid", 64'(m_valid_o), 64'd0);
    check_output("mid_rst_rd_en", 64'(fifo_rd_en_o), 64'd0);
    check_output("mid_rst_pop_cnt", 64'(pop_cnt_o), 64'd0);
    repeat (2) next_cycle();
    rstn_i    = 1'b1;
    m_ready_i = 1'b1;
    repeat (6) begin
      next_cycle();
      check_output("post_rst_valid", 64'(m_valid_o), 64'd0);
      check_output("post_rst_data", 64'(m_data_o), 64'd0);
      check_output("post_rst_idle", 64'(idle_o), 64'd1);
      check_output("post_rst_pop_cnt", 64'(pop_cnt_o), 64'd0);
    end

    // Recovery after reset
    apply_stimulus(32'h1234_5678);
    wait_drained(30);
    check_output("recover_pop_cnt", 64'(pop_cnt_o), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
